// File: rtl/m_mem_pkg.sv
// rtl/m_mem_pkg.sv - opcodes, state/size enums and load/store opcode decode for the MEM stage
package m_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        mem_size_t size;
        logic      sign;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t op;
        op = '{is_mem: 1'b0, is_load: 1'b0, size: WORD, sign: 1'b0};
        case (opcode)
            OP_LB:  op = '{is_mem: 1'b1, is_load: 1'b1, size: BYTE, sign: 1'b1};
            OP_LH:  op = '{is_mem: 1'b1, is_load: 1'b1, size: HALF, sign: 1'b1};
            OP_LW:  op = '{is_mem: 1'b1, is_load: 1'b1, size: WORD, sign: 1'b0};
            OP_LBU: op = '{is_mem: 1'b1, is_load: 1'b1, size: BYTE, sign: 1'b0};
            OP_LHU: op = '{is_mem: 1'b1, is_load: 1'b1, size: HALF, sign: 1'b0};
            OP_SB:  op = '{is_mem: 1'b1, is_load: 1'b0, size: BYTE, sign: 1'b0};
            OP_SH:  op = '{is_mem: 1'b1, is_load: 1'b0, size: HALF, sign: 1'b0};
            OP_SW:  op = '{is_mem: 1'b1, is_load: 1'b0, size: WORD, sign: 1'b0};
            default: ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/m_lsu_align.sv
// rtl/m_lsu_align.sv - byte-lane alignment: store enables/replication and load extraction/extension
module m_lsu_align
    import m_mem_pkg::*;
(
    input  logic [1:0]  st_off,
    input  mem_size_t   st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [31:0] ld_rdata,
    input  logic [1:0]  ld_off,
    input  mem_size_t   ld_size,
    input  logic        ld_sign,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            HALF: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            BYTE:    ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            HALF:    ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/m_mem_stage.sv
// rtl/m_mem_stage.sv - MEM stage: load/store handshake FSM with wait states, timeout and sticky error
module m_mem_stage
    import m_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdata,
    output logic        stallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state;
    mem_op_t          op;
    logic             misaligned;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_off;
    mem_size_t        lat_size;
    logic             lat_sign;
    logic             lat_load;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;
    logic             unused_bits;

    assign op          = decode_mem_op(instrM[31:26]);
    assign unused_bits = ^instrM[25:0];
    assign misaligned  = ((op.size == WORD) && (aluoutM[1:0] != 2'b00)) ||
                         ((op.size == HALF) && aluoutM[0]);

    // Store side aligns the live address; load side uses what was latched at request time.
    m_lsu_align u_align (
        .st_off   (aluoutM[1:0]),
        .st_size  (op.size),
        .st_data  (writedataM),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_rdata (mem_rdata),
        .ld_off   (lat_off),
        .ld_size  (lat_size),
        .ld_sign  (lat_sign),
        .ld_data  (ld_data)
    );

    always_comb begin
        stallM = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stallM = op.is_mem;
                BUSY:    stallM = 1'b1;
                default: stallM = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_err   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            readdata  <= '0;
            cnt       <= '0;
            lat_off   <= '0;
            lat_size  <= WORD;
            lat_sign  <= 1'b0;
            lat_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op.is_mem) begin
                        if (misaligned) begin
                            mem_err <= 1'b1;
                            if (op.is_load) readdata <= '0;
                            state <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= !op.is_load;
                            mem_addr  <= aluoutM[31:2];
                            mem_be    <= st_be;
                            mem_wdata <= st_wdata;
                            lat_off   <= aluoutM[1:0];
                            lat_size  <= op.size;
                            lat_sign  <= op.sign;
                            lat_load  <= op.is_load;
                            cnt       <= '0;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (lat_load) readdata <= ld_data;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        if (lat_load) readdata <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_stage.sv
// tb/tb_m_mem_stage.sv - scoreboard bench for m_mem_stage with a wait-state memory responder
module tb_m_mem_stage;
    import m_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrM = '0;
    logic [31:0] aluoutM = '0;
    logic [31:0] writedataM = '0;
    logic [31:0] readdata;
    logic        stallM;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_err;

    m_mem_stage #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .instrM     (instrM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdata   (readdata),
        .stallM     (stallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stalls;
        int          reqc;
        logic [29:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t req_q[$];
    exp_t cmp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   wait_states = 0;
    logic hang = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: assert ready after wait_states BUSY cycles unless hanging.
    initial begin
        int wc;
        wc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                mem_ready = (wc == wait_states) && !hang;
                wc++;
            end else begin
                mem_ready = 1'b0;
                wc = 0;
            end
        end
    end

    // Monitor: checks each request launch/hold and each DONE cycle against the queues.
    initial begin
        logic prev_stall, prev_req;
        int   stall_cnt, req_cnt;
        exp_t cur, snap;
        prev_stall = 1'b0; prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 1'b0; prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
            end else begin
                if (stallM) stall_cnt++;
                if (mem_req) begin
                    if (!prev_req) begin
                        if (req_q.size() == 0) begin
                            chk("req_unexpected", 32'd1, 32'd0);
                        end else begin
                            cur = req_q.pop_front();
                            chk("req_addr", {2'b0, mem_addr}, {2'b0, cur.addr});
                            chk("req_be", {28'b0, mem_be}, {28'b0, cur.be});
                            chk("req_we", {31'b0, mem_we}, {31'b0, cur.we});
                            if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
                        end
                        snap.addr = mem_addr; snap.be = mem_be; snap.we = mem_we; snap.wdata = mem_wdata;
                    end else begin
                        chk("req_stable",
                            {31'b0, (mem_addr == snap.addr) && (mem_be == snap.be) &&
                                    (mem_we == snap.we) && (mem_wdata == snap.wdata)}, 32'd1);
                    end
                    req_cnt++;
                end
                if (prev_stall && !stallM) begin
                    if (cmp_q.size() == 0) begin
                        chk("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur = cmp_q.pop_front();
                        chk("readdata", readdata, cur.rd);
                        chk("mem_err", {31'b0, mem_err}, {31'b0, cur.err});
                        chk("stall_cycles", stall_cnt, cur.stalls);
                        chk("req_cycles", req_cnt, cur.reqc);
                    end
                    stall_cnt = 0;
                    req_cnt = 0;
                end
                prev_stall = stallM;
                prev_req = mem_req;
            end
        end
    end

    task automatic issue(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdw, input int ws, input logic hng,
                         input logic [31:0] erd, input logic eerr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input int estalls, input int ereqc);
        exp_t e;
        bit   done;
        e.rd = erd; e.err = eerr; e.stalls = estalls; e.reqc = ereqc;
        e.addr = addr[31:2]; e.be = ebe; e.we = opc[3]; e.wdata = ewd;
        cmp_q.push_back(e);
        if (ereqc > 0) req_q.push_back(e);
        wait_states = ws;
        hang = hng;
        mem_rdata = rdw;
        instrM = {opc, 26'b0};
        aluoutM = addr;
        writedataM = wd;
        done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!stallM) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        instrM = '0;
        hang = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instrM = {OP_LW, 26'b0};
        aluoutM = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'b0, stallM}, 32'd0);
        chk("reset_req", {31'b0, mem_req}, 32'd0);
        chk("reset_err", {31'b0, mem_err}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_addr", {2'b0, mem_addr}, 32'd0);
        chk("reset_be", {28'b0, mem_be}, 32'd0);
        instrM = '0;
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        //    opcode  addr      wd            rdata         ws hang exp_rd        err   be       wdata         st req
        issue(OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        2, 1);
        issue(OP_LB,  32'h103, 32'h0,        32'h80112233, 0, 0,  32'hFFFFFF80, 1'b0, 4'b1000, 32'h0,        2, 1);
        issue(OP_LBU, 32'h103, 32'h0,        32'h80112233, 0, 0,  32'h00000080, 1'b0, 4'b1000, 32'h0,        2, 1);
        issue(OP_LHU, 32'h102, 32'h0,        32'h80112233, 0, 0,  32'h00008011, 1'b0, 4'b1100, 32'h0,        2, 1);
        issue(OP_LH,  32'h102, 32'h0,        32'h80112233, 0, 0,  32'hFFFF8011, 1'b0, 4'b1100, 32'h0,        2, 1);
        issue(OP_LH,  32'h100, 32'h0,        32'h80112233, 0, 0,  32'h00002233, 1'b0, 4'b0011, 32'h0,        2, 1);
        issue(OP_SH,  32'h006, 32'h0000ABCD, 32'hFFFFFFFF, 0, 0,  32'h00002233, 1'b0, 4'b1100, 32'hABCDABCD, 2, 1);
        issue(OP_SB,  32'h00D, 32'h123456EF, 32'hFFFFFFFF, 0, 0,  32'h00002233, 1'b0, 4'b0010, 32'hEFEFEFEF, 2, 1);
        issue(OP_SW,  32'h010, 32'h01234567, 32'hFFFFFFFF, 0, 0,  32'h00002233, 1'b0, 4'b1111, 32'h01234567, 2, 1);
        issue(OP_LW,  32'h200, 32'h0,        32'hCAFEF00D, 3, 0,  32'hCAFEF00D, 1'b0, 4'b1111, 32'h0,        5, 4);
        issue(OP_LW,  32'h300, 32'h0,        32'h55555555, 0, 1,  32'h00000000, 1'b1, 4'b1111, 32'h0,        17, 16);
        issue(OP_LW,  32'h104, 32'h0,        32'h11223344, 1, 0,  32'h11223344, 1'b1, 4'b1111, 32'h0,        3, 2);
        issue(OP_LW,  32'h102, 32'h0,        32'h77777777, 0, 0,  32'h00000000, 1'b1, 4'b1111, 32'h0,        1, 0);
        issue(OP_LBU, 32'h101, 32'h0,        32'h80112233, 0, 0,  32'h00000022, 1'b1, 4'b0010, 32'h0,        2, 1);
        issue(OP_SH,  32'h005, 32'h0000BEEF, 32'hFFFFFFFF, 0, 0,  32'h00000022, 1'b1, 4'b1100, 32'hBEEFBEEF, 1, 0);

        mon_en = 1'b0;
        hang = 1'b1;
        instrM = {OP_LW, 26'b0};
        aluoutM = 32'h400;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("busy_req_before_reset", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("stall_during_reset", {31'b0, stallM}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_req", {31'b0, mem_req}, 32'd0);
        chk("abort_err", {31'b0, mem_err}, 32'd0);
        chk("abort_readdata", readdata, 32'd0);
        reset = 1'b0;
        hang = 1'b0;
        instrM = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        issue(OP_LW,  32'h100, 32'h0,        32'h0DEADBEE, 0, 0,  32'h0DEADBEE, 1'b0, 4'b1111, 32'h0,        2, 1);

        repeat (2) @(posedge clk);
        chk("req_queue_empty", req_q.size(), 32'd0);
        chk("cmp_queue_empty", cmp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_mem_stage.md
# m_mem_stage

Data-memory access stage of the 5-stage pipeline, located between the EX/MEM pipeline register and the MEM/WB pipeline register. Decodes load/store opcodes from the instruction in MEM and runs a request/ready handshake with an external data memory that may insert wait states. Produces byte/half/word-aligned, sign- or zero-extended `readdata` for the MEM/WB register. Stalls the pipeline through `stallM` until the access completes.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum BUSY cycles without `mem_ready` before the access is abandoned.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `instrM` in 32: instruction in MEM; opcode is `instrM[31:26]`.
- `aluoutM` in 32: effective byte address.
- `writedataM` in 32: store data (rt value).
- `readdata` out 32: extended load result, registered; feeds the MEM/WB register.
- `stallM` out 1: combinational; 1 freezes IF/ID/EX/MEM.
- `mem_req` out 1: registered memory request.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 30: word address, equal to `aluoutM[31:2]` latched.
- `mem_be` out 4: byte enables; bit i = byte lane i (little-endian).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read word, valid when `mem_ready`=1.
- `mem_ready` in 1: completes the current request.
- `mem_err` out 1: sticky error (misalignment or timeout).

## Operation
- Memory ops are LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. All other opcodes are non-memory.
- FSM states: IDLE, BUSY, DONE.
- IDLE with a memory op, aligned:
  - `stallM`=1.
  - Next edge: latch addr/be/wdata/size/sign, set `mem_req`=1 and `mem_we`, clear the wait counter, go to BUSY.
- IDLE with a misaligned memory op (LW/SW `addr[1:0]`≠0; LH/LHU/SH `addr[0]`=1):
  - `stallM`=1.
  - Next edge: no request is issued, `mem_err`<=1, `readdata`<=0 if the op is a load, go to DONE.
- IDLE with a non-memory op: `stallM`=0, `readdata` holds its value.
- BUSY: `stallM`=1.
  - `mem_ready`=1: if load, `readdata`<=extract(`mem_rdata`); `mem_req`<=0; go to DONE.
  - Otherwise, counter+1. When the counter reaches `TIMEOUT`-1 with no ready: `mem_req`<=0, `mem_err`<=1, load `readdata`<=0, go to DONE.
- DONE: `stallM`=0, so the pipeline and MEM/WB capture on this edge. Next state is IDLE.
- Load extract:
  - LB/LBU: byte lane `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: lanes {`addr[1]`*2+1, `addr[1]`*2}, sign- or zero-extended.
  - LW: whole word.
- Store:
  - SB: `be`=1<<`addr[1:0]`, wdata = {4{rt[7:0]}}.
  - SH: `be`=0011 or 1100, wdata = {2{rt[15:0]}}.
  - SW: `be`=1111.
- Stores leave `readdata` unchanged.
- `mem_ready` is ignored when `mem_req`=0.
- `mem_err` clears only on reset.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_err`=0; `mem_addr`, `mem_be`, `mem_wdata`, `readdata`=0; counter 0. `stallM`=0 while `reset`=1.
- Zero-wait access takes 3 cycles in MEM: IDLE, BUSY with ready, DONE. That is 2 stall cycles.
- Each wait state adds 1 cycle.
- `mem_req` and all `mem_*` outputs stay stable from the assert edge until the edge sampling `mem_ready`=1.
- `readdata` is valid from the DONE cycle onward.
- Back-to-back memory ops: DONE→IDLE, then the next op starts in IDLE. There is no overlap.
- Reset during BUSY aborts: `mem_req`=0 after the reset edge, and no write-back occurs.

## Structure
- Package `m_mem_pkg` holds:
  - opcode localparams;
  - `mem_state_t` enum {IDLE, BUSY, DONE};
  - `mem_size_t` enum {BYTE, HALF, WORD};
  - the `decode_mem_op` function.
- Sub-module `m_lsu_align` is purely combinational:
  - store side: address, size, data → be, wdata.
  - load side: rdata, offset, size, sign → extended result.
- The FSM, counter and registers live in `m_mem_stage`.

## Test plan
- LW at 0x100, `mem_ready` immediately, rdata 0xDEADBEEF → `stallM`=1 for 2 cycles, `mem_addr`=0x40, `be`=1111, `readdata`=0xDEADBEEF in DONE.
- LB at 0x103, rdata 0x80112233 → `readdata`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008011.
- SH at 0x06, rt=0x0000ABCD → `mem_we`=1, `be`=1100, wdata=0xABCDABCD, `readdata` unchanged.
- LW with 3 wait states → `mem_req` held for 4 cycles with stable outputs, then 1 DONE cycle; `stallM` high for 5 cycles.
- LW at 0x102 → no `mem_req`, `mem_err`=1, `readdata`=0. Separately, no `mem_ready` with `TIMEOUT`=16 → `mem_req` drops after 16 BUSY cycles, `mem_err`=1.
- Reset asserted in the 2nd BUSY cycle → state IDLE, `mem_req`=0, `mem_err`=0, `readdata`=0 after the edge; a following LW completes normally.
